serial_cla_adder: RTL and testbench

Wide-operand adder that wraps the team's 4-bit carry-lookahead adder `CLA` and drives it one nibble per clock, least-significant first, with the carry registered between nibbles. It sits directly upstream of `CLA`: it sources the `a`, `b` and `cin` inputs, then consumes the `sum` and `cout` outputs. Operands arrive and results leave over valid/ready handshakes. This lets datapaths wider than 4 bits reuse the verified 4-bit slice at one nibble per cycle.

---
 rtl/serial_cla_adder.sv | 173 +++++++++++++++++
 tb/tb_serial_cla_adder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cla_adder.sv
// Wide adder built from one 4-bit carry-lookahead slice, stepped one nibble per clock LSB first.
// Latency: operands accepted at edge k, result valid from edge k+NIBBLES (NIBBLES+2 cycles per op minimum).
// Backpressure: result held in DONE while out_ready=0; in_ready is low everywhere except IDLE.

// 4-bit carry-lookahead slice: generate/propagate terms resolve all internal carries in one level.
module CLA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Lookahead carries expanded explicitly so no carry ripples through another carry term.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

module serial_cla_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 busy
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q,   idx_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q,   sum_d;
    logic            cout_q,  cout_d;

    logic [3:0]      cla_a;
    logic [3:0]      cla_b;
    logic [3:0]      cla_sum;
    logic            cla_cout;

    // Select the current nibble of each latched operand for the slice.
    always_comb begin
        cla_a = '0;
        cla_b = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDXW'(n)) begin
                cla_a = a_q[4*n +: 4];
                cla_b = b_q[4*n +: 4];
            end
        end
    end

    // The only carry path between nibbles goes through carry_q.
    CLA u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // Next-state and datapath update: accept in IDLE, one nibble per ADD cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    // Unwritten result nibbles read as zero while the add is in progress.
                    sum_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDXW'(n)) begin
                        sum_d[4*n +: 4] = cla_sum;
                    end
                end
                carry_d = cla_cout;
                if (idx_q == IDX_LAST) begin
                    // idx parks on the last nibble instead of wrapping.
                    cout_d  = cla_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset wins over every handshake and aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // in_ready is gated by rst so nothing looks acceptable during a reset cycle.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        sum       = sum_q;
        cout      = cout_q;
    end

endmodule

// File: tb/tb_serial_cla_adder.sv
// Bench for serial_cla_adder: directed test-plan steps plus random vectors on NIBBLES=4 and NIBBLES=1.
// Expected results come from plain integer addition; latency is counted in clock edges.
// Backpressure, ignored in_valid and reset-abort behaviour are exercised on the 4-nibble instance.
module tb_serial_cla_adder;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, busy4;
    logic [15:0] a4, b4, sum4;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [3:0]  a1, b1, sum1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_cla_adder #(.NIBBLES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .busy      (busy4)
    );

    serial_cla_adder #(.NIBBLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the 4-nibble instance, with 'hold' cycles of out_ready=0 in DONE.
    task automatic run4(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input int hold);
        logic [16:0] exp;
        int          lat;
        exp = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
        chk("n4_in_ready", in_ready4, 1);
        a4 = ta; b4 = tb; cin4 = tc; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            tick();
            lat++;
        end
        chk("n4_latency", lat, 4);
        chk("n4_sum", sum4, exp[15:0]);
        chk("n4_cout", cout4, exp[16]);
        repeat (hold) begin
            tick();
            chk("n4_hold_valid", out_valid4, 1);
            chk("n4_hold_sum", sum4, exp[15:0]);
        end
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("n4_valid_drop", out_valid4, 0);
        chk("n4_sum_kept", {cout4, sum4}, exp);
    endtask

    // One full transaction on the 1-nibble instance.
    task automatic run1(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        logic [4:0] exp;
        int         lat;
        exp = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
        chk("n1_in_ready", in_ready1, 1);
        a1 = ta; b1 = tb; cin1 = tc; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("n1_latency", lat, 1);
        chk("n1_result", {cout1, sum1}, exp);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk("n1_valid_drop", out_valid1, 0);
    endtask

    initial begin
        logic [15:0] held_sum;
        logic        held_cout;
        int          lat;
        int          pulses;

        rst = 1'b1;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();

        // Reset state.
        chk("rst_in_ready", in_ready4, 0);
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_sum", sum4, 0);
        chk("rst_cout", cout4, 0);
        chk("rst_carry", dut4.carry_q, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready4", in_ready4, 1);
        chk("post_rst_in_ready1", in_ready1, 1);
        tick();

        // Zero operands, exact latency of 4.
        run4(16'h0000, 16'h0000, 1'b0, 0);

        // Full carry ripple, carry register checked after every nibble.
        a4 = 16'hFFFF; b4 = 16'h0001; cin4 = 1'b0; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        chk("ripple_busy", busy4, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("ripple_carry_n%0d", i), dut4.carry_q, 1);
        end
        chk("ripple_valid", out_valid4, 1);
        chk("ripple_sum", sum4, 16'h0000);
        chk("ripple_cout", cout4, 1);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;

        // Carry-in and top-nibble overflow.
        run4(16'h1234, 16'h4321, 1'b1, 1);
        chk("cin_case_sum", sum4, 16'h5556);
        run4(16'h6000, 16'hF000, 1'b0, 0);
        chk("ovf_case_cout", cout4, 1);
        run4(16'hFFFF, 16'hFFFF, 1'b1, 2);

        // Backpressure with in_valid pulsed during DONE.
        a4 = 16'hABCD; b4 = 16'h1111; cin4 = 1'b0; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_latency", lat, 4);
        held_sum  = sum4;
        held_cout = cout4;
        chk("bp_result", {held_cout, held_sum}, 17'h0BCDE);
        for (int i = 0; i < 3; i++) begin
            in_valid4 = 1'b1; a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
            #1;
            chk("bp_in_ready", in_ready4, 0);
            tick();
            chk("bp_valid", out_valid4, 1);
            chk("bp_sum_stable", {cout4, sum4}, {held_cout, held_sum});
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("bp_idle_ready", in_ready4, 1);
        chk("bp_idle_busy", busy4, 0);
        tick();
        chk("bp_not_latched", {busy4, cout4, sum4}, {1'b0, held_cout, held_sum});

        // Reset while idx=2: operation aborted, never reported.
        a4 = 16'h7777; b4 = 16'h8888; cin4 = 1'b1; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick();
        tick();
        chk("abort_idx", dut4.idx_q, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_busy", busy4, 0);
        chk("abort_in_ready", in_ready4, 1);
        chk("abort_out_valid", out_valid4, 0);
        chk("abort_sum", sum4, 0);
        chk("abort_cout", cout4, 0);
        pulses = 0;
        repeat (8) begin
            tick();
            if (out_valid4) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);

        // NIBBLES=1 directed cases.
        run1(4'hC, 4'h2, 1'b1);
        chk("n1_case1", {cout1, sum1}, 5'h0F);
        run1(4'h6, 4'hF, 1'b0);
        chk("n1_case2", {cout1, sum1}, 5'h15);

        // Random vectors against the arithmetic model.
        for (int i = 0; i < 16; i++) begin
            run4(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 10; i++) begin
            run1(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
